// File: rtl/pll_dyn_ctrl.sv
// PLL supervisor: sequences PLL reset, qualifies lock with timeout and bounded retry,
// gates the output clocks, and loads new divider ratios through a valid/ready handshake.
module pll_dyn_ctrl #(
    parameter int unsigned                NUM_CH       = 3,
    parameter int unsigned                RATIO_W      = 10,
    parameter logic [RATIO_W-1:0]         DEF_RATIOI   = 2,
    parameter logic [RATIO_W-1:0]         DEF_RATIOF   = 40,
    parameter logic [NUM_CH*RATIO_W-1:0]  DEF_RATIO_O  = {10'd2, 10'd5, 10'd4},
    parameter int unsigned                RST_CYCLES   = 16,
    parameter int unsigned                LOCK_STABLE  = 64,
    parameter int unsigned                LOCK_TIMEOUT = 4096,
    parameter int unsigned                MAX_RETRY    = 3
) (
    input  logic                        clkin1,
    input  logic                        rst,
    input  logic                        pll_lock,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [RATIO_W-1:0]          cfg_ratio_i,
    input  logic [RATIO_W-1:0]          cfg_ratio_f,
    input  logic [NUM_CH*RATIO_W-1:0]   cfg_ratio_o,
    output logic                        cfg_err,
    output logic [RATIO_W-1:0]          dyn_idiv,
    output logic [RATIO_W-1:0]          dyn_fdiv,
    output logic [NUM_CH*RATIO_W-1:0]   dyn_odiv,
    output logic                        pll_rst,
    output logic [NUM_CH-1:0]           clkout_gate,
    output logic                        pll_ready,
    output logic                        pll_fail,
    output logic [7:0]                  lock_loss_cnt
);

    localparam int unsigned CNT_M1  = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
    localparam int unsigned CNT_MAX = (CNT_M1 > LOCK_TIMEOUT) ? CNT_M1 : LOCK_TIMEOUT;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        S_RST,
        S_WAIT,
        S_STAB,
        S_RUN,
        S_FAIL
    } state_t;

    state_t                      state, state_n;
    logic [CNT_W-1:0]            cnt, cnt_n;
    logic [RETRY_W-1:0]          retry, retry_n;
    logic                        lock_m, lock_s;
    logic                        cfg_bad;
    logic                        cfg_take;
    logic                        err_n;
    logic [7:0]                  loss_n;
    logic [RATIO_W-1:0]          idiv_n, fdiv_n;
    logic [NUM_CH*RATIO_W-1:0]   odiv_n;

    always_ff @(posedge clkin1 or posedge rst) begin
        if (rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    always_comb begin
        cfg_bad = (cfg_ratio_i == '0) || (cfg_ratio_f == '0);
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            if (cfg_ratio_o[ch*RATIO_W +: RATIO_W] == '0) begin
                cfg_bad = 1'b1;
            end
        end
    end

    // cfg_ready is registered from the next state, so it is high exactly in RUN and FAIL
    assign cfg_take = cfg_valid && cfg_ready;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        retry_n = retry;
        loss_n  = lock_loss_cnt;
        idiv_n  = dyn_idiv;
        fdiv_n  = dyn_fdiv;
        odiv_n  = dyn_odiv;
        err_n   = 1'b0;

        case (state)
            S_RST: begin
                if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                    state_n = S_WAIT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (lock_s) begin
                    state_n = S_STAB;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    cnt_n = '0;
                    if (retry == RETRY_W'(MAX_RETRY)) begin
                        state_n = S_FAIL;
                    end else begin
                        retry_n = retry + RETRY_W'(1);
                        state_n = S_RST;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_STAB: begin
                if (!lock_s) begin
                    state_n = S_WAIT;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(LOCK_STABLE - 1)) begin
                    state_n = S_RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    if (lock_loss_cnt != 8'hFF) begin
                        loss_n = lock_loss_cnt + 8'd1;
                    end
                    retry_n = '0;
                    state_n = S_RST;
                    cnt_n   = '0;
                end
            end
            S_FAIL: begin
                state_n = S_FAIL;
            end
            default: begin
                state_n = S_RST;
                cnt_n   = '0;
            end
        endcase

        // Handshake is evaluated last so an accepted cfg coinciding with lock loss keeps
        // the loss count increment and still yields a single S_RST entry.
        if (cfg_take) begin
            if (cfg_bad) begin
                err_n = 1'b1;
            end else begin
                idiv_n  = cfg_ratio_i;
                fdiv_n  = cfg_ratio_f;
                odiv_n  = cfg_ratio_o;
                retry_n = '0;
                state_n = S_RST;
                cnt_n   = '0;
            end
        end
    end

    always_ff @(posedge clkin1 or posedge rst) begin
        if (rst) begin
            state         <= S_RST;
            cnt           <= '0;
            retry         <= '0;
            lock_loss_cnt <= '0;
            dyn_idiv      <= DEF_RATIOI;
            dyn_fdiv      <= DEF_RATIOF;
            dyn_odiv      <= DEF_RATIO_O;
            cfg_err       <= 1'b0;
            pll_rst       <= 1'b1;
            clkout_gate   <= '0;
            pll_ready     <= 1'b0;
            pll_fail      <= 1'b0;
            cfg_ready     <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            retry         <= retry_n;
            lock_loss_cnt <= loss_n;
            dyn_idiv      <= idiv_n;
            dyn_fdiv      <= fdiv_n;
            dyn_odiv      <= odiv_n;
            cfg_err       <= err_n;
            pll_rst       <= (state_n == S_RST) || (state_n == S_FAIL);
            clkout_gate   <= (state_n == S_RUN) ? '1 : '0;
            pll_ready     <= (state_n == S_RUN);
            pll_fail      <= (state_n == S_FAIL);
            cfg_ready     <= (state_n == S_RUN) || (state_n == S_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Directed bench for pll_dyn_ctrl: power-up, handshake, lock loss, glitch, retry/fail paths.
module tb_pll_dyn_ctrl;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned RW     = 10;
    localparam logic [NUM_CH*RW-1:0] O_DEF  = {10'd2, 10'd5, 10'd4};
    localparam logic [NUM_CH*RW-1:0] O_BAD  = {10'd6, 10'd0, 10'd3};
    localparam logic [NUM_CH*RW-1:0] O_NEW  = {10'd3, 10'd6, 10'd6};
    localparam logic [NUM_CH*RW-1:0] O_NEW2 = {10'd7, 10'd8, 10'd9};

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   pll_lock = 1'b0;
    logic                   cfg_valid = 1'b0;
    logic                   cfg_ready;
    logic [RW-1:0]          cfg_ratio_i = '0;
    logic [RW-1:0]          cfg_ratio_f = '0;
    logic [NUM_CH*RW-1:0]   cfg_ratio_o = '0;
    logic                   cfg_err;
    logic [RW-1:0]          dyn_idiv, dyn_fdiv;
    logic [NUM_CH*RW-1:0]   dyn_odiv;
    logic                   pll_rst;
    logic [NUM_CH-1:0]      clkout_gate;
    logic                   pll_ready, pll_fail;
    logic [7:0]             lock_loss_cnt;

    int tests = 0;
    int fails = 0;
    int hi_cycles;
    int pulses;
    logic prev_rst;
    logic early_fail;

    pll_dyn_ctrl #(
        .NUM_CH      (NUM_CH),
        .RATIO_W     (RW),
        .DEF_RATIOI  (10'd2),
        .DEF_RATIOF  (10'd40),
        .DEF_RATIO_O (O_DEF),
        .RST_CYCLES  (16),
        .LOCK_STABLE (64),
        .LOCK_TIMEOUT(100),
        .MAX_RETRY   (3)
    ) dut (
        .clkin1       (clk),
        .rst          (rst),
        .pll_lock     (pll_lock),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ratio_i  (cfg_ratio_i),
        .cfg_ratio_f  (cfg_ratio_f),
        .cfg_ratio_o  (cfg_ratio_o),
        .cfg_err      (cfg_err),
        .dyn_idiv     (dyn_idiv),
        .dyn_fdiv     (dyn_fdiv),
        .dyn_odiv     (dyn_odiv),
        .pll_rst      (pll_rst),
        .clkout_gate  (clkout_gate),
        .pll_ready    (pll_ready),
        .pll_fail     (pll_fail),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        step(3);
        check("rst_pll_rst",  64'(pll_rst),       64'd1);
        check("rst_gate",     64'(clkout_gate),   64'd0);
        check("rst_ready",    64'(pll_ready),     64'd0);
        check("rst_fail",     64'(pll_fail),      64'd0);
        check("rst_cfg_rdy",  64'(cfg_ready),     64'd0);
        check("rst_cfg_err",  64'(cfg_err),       64'd0);
        check("rst_loss",     64'(lock_loss_cnt), 64'd0);
        check("rst_idiv",     64'(dyn_idiv),      64'd2);
        check("rst_fdiv",     64'(dyn_fdiv),      64'd40);
        check("rst_odiv",     64'(dyn_odiv),      64'(O_DEF));

        // Power-up: pll_rst held 16 cycles, lock 20 cycles later, RUN 3+64 after lock
        rst = 1'b0;
        step(15);
        check("pu_rst_hold",  64'(pll_rst),       64'd1);
        step(1);
        check("pu_rst_fall",  64'(pll_rst),       64'd0);
        step(20);
        pll_lock = 1'b1;
        step(66);
        check("pu_ready_early", 64'(pll_ready),   64'd0);
        step(1);
        check("pu_ready",     64'(pll_ready),     64'd1);
        check("pu_gate",      64'(clkout_gate),   64'd7);
        check("pu_cfg_rdy",   64'(cfg_ready),     64'd1);
        check("pu_idiv",      64'(dyn_idiv),      64'd2);
        check("pu_fdiv",      64'(dyn_fdiv),      64'd40);
        check("pu_odiv",      64'(dyn_odiv),      64'(O_DEF));

        // Rejected cfg in RUN (channel 1 ratio zero)
        cfg_ratio_i = 10'd1;
        cfg_ratio_f = 10'd30;
        cfg_ratio_o = O_BAD;
        cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        check("bad_err",      64'(cfg_err),       64'd1);
        check("bad_idiv",     64'(dyn_idiv),      64'd2);
        check("bad_odiv",     64'(dyn_odiv),      64'(O_DEF));
        check("bad_ready",    64'(pll_ready),     64'd1);
        step(1);
        check("bad_err_clr",  64'(cfg_err),       64'd0);
        check("bad_cfg_rdy",  64'(cfg_ready),     64'd1);

        // Accepted cfg in RUN
        cfg_ratio_o = O_NEW;
        cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        check("cfg_pll_rst",  64'(pll_rst),       64'd1);
        check("cfg_idiv",     64'(dyn_idiv),      64'd1);
        check("cfg_fdiv",     64'(dyn_fdiv),      64'd30);
        check("cfg_odiv",     64'(dyn_odiv),      64'(O_NEW));
        check("cfg_gate",     64'(clkout_gate),   64'd0);
        check("cfg_cfg_rdy",  64'(cfg_ready),     64'd0);
        step(15);
        check("cfg_rst_hold", 64'(pll_rst),       64'd1);
        step(1);
        check("cfg_rst_fall", 64'(pll_rst),       64'd0);
        step(64);
        check("cfg_run_early", 64'(pll_ready),    64'd0);
        step(1);
        check("cfg_run",      64'(pll_ready),     64'd1);

        // Lock drop in RUN
        pll_lock = 1'b0;
        step(2);
        check("drop_gate_hold", 64'(clkout_gate), 64'd7);
        step(1);
        check("drop_gate",    64'(clkout_gate),   64'd0);
        check("drop_pll_rst", 64'(pll_rst),       64'd1);
        check("drop_loss",    64'(lock_loss_cnt), 64'd1);
        pll_lock = 1'b1;
        step(80);
        check("relock_early", 64'(pll_ready),     64'd0);
        step(1);
        check("relock_run",   64'(pll_ready),     64'd1);
        check("relock_idiv",  64'(dyn_idiv),      64'd1);

        // Lock glitch at stability count 40
        pll_lock = 1'b0;
        step(3);
        check("gl_loss",      64'(lock_loss_cnt), 64'd2);
        pll_lock = 1'b1;
        step(57);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(66);
        check("gl_run_early", 64'(pll_ready),     64'd0);
        step(1);
        check("gl_run",       64'(pll_ready),     64'd1);
        check("gl_loss_hold", 64'(lock_loss_cnt), 64'd2);

        // rst asserted mid-S_STAB
        pll_lock = 1'b0;
        step(3);
        pll_lock = 1'b1;
        step(50);
        rst = 1'b1;
        #1;
        check("mid_pll_rst",  64'(pll_rst),       64'd1);
        check("mid_ready",    64'(pll_ready),     64'd0);
        check("mid_loss",     64'(lock_loss_cnt), 64'd0);
        check("mid_idiv",     64'(dyn_idiv),      64'd2);
        check("mid_fdiv",     64'(dyn_fdiv),      64'd40);
        check("mid_odiv",     64'(dyn_odiv),      64'(O_DEF));
        step(2);
        rst = 1'b0;
        step(80);
        check("mid_run_early", 64'(pll_ready),    64'd0);
        step(1);
        check("mid_run",      64'(pll_ready),     64'd1);

        // 256 lock losses, counter saturates at 255
        for (int i = 1; i <= 256; i++) begin
            pll_lock = 1'b0;
            step(3);
            pll_lock = 1'b1;
            step(81);
            if (i == 100) check("sat_100", 64'(lock_loss_cnt), 64'd100);
        end
        check("sat_255",      64'(lock_loss_cnt), 64'd255);
        check("sat_run",      64'(pll_ready),     64'd1);

        // Never lock: four 16-cycle pll_rst pulses, FAIL 464 cycles after release
        pll_lock = 1'b0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        hi_cycles = 0;
        pulses = 0;
        prev_rst = 1'b0;
        early_fail = 1'b0;
        for (int n = 0; n < 464; n++) begin
            if (pll_rst) hi_cycles++;
            if (pll_rst && !prev_rst) pulses++;
            if (pll_fail) early_fail = 1'b1;
            prev_rst = pll_rst;
            step(1);
        end
        check("nl_early_fail", 64'(early_fail),   64'd0);
        check("nl_hi_cycles", 64'(hi_cycles),     64'd64);
        check("nl_pulses",    64'(pulses),        64'd4);
        check("nl_fail",      64'(pll_fail),      64'd1);
        check("nl_cfg_rdy",   64'(cfg_ready),     64'd1);
        check("nl_pll_rst",   64'(pll_rst),       64'd1);

        // Rejected then accepted cfg from FAIL
        cfg_ratio_o = O_BAD;
        cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        check("fb_err",       64'(cfg_err),       64'd1);
        check("fb_fail_hold", 64'(pll_fail),      64'd1);
        check("fb_idiv",      64'(dyn_idiv),      64'd2);
        cfg_ratio_o = O_NEW;
        cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        check("fg_pll_rst",   64'(pll_rst),       64'd1);
        check("fg_fail",      64'(pll_fail),      64'd0);
        check("fg_cfg_rdy",   64'(cfg_ready),     64'd0);
        check("fg_idiv",      64'(dyn_idiv),      64'd1);
        check("fg_odiv",      64'(dyn_odiv),      64'(O_NEW));
        step(115);
        check("fg_wait",      64'(pll_rst),       64'd0);
        step(1);
        check("fg_retry_rst", 64'(pll_rst),       64'd1);
        check("fg_retry_nofail", 64'(pll_fail),   64'd0);
        pll_lock = 1'b1;
        step(80);
        check("fg_run_early", 64'(pll_ready),     64'd0);
        step(1);
        check("fg_run",       64'(pll_ready),     64'd1);

        // Lock loss and accepted cfg on the same edge
        pll_lock = 1'b0;
        step(2);
        cfg_ratio_i = 10'd3;
        cfg_ratio_f = 10'd50;
        cfg_ratio_o = O_NEW2;
        cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        check("sim_pll_rst",  64'(pll_rst),       64'd1);
        check("sim_idiv",     64'(dyn_idiv),      64'd3);
        check("sim_fdiv",     64'(dyn_fdiv),      64'd50);
        check("sim_odiv",     64'(dyn_odiv),      64'(O_NEW2));
        check("sim_loss",     64'(lock_loss_cnt), 64'd1);
        check("sim_gate",     64'(clkout_gate),   64'd0);
        step(15);
        check("sim_rst_hold", 64'(pll_rst),       64'd1);
        step(1);
        check("sim_rst_fall", 64'(pll_rst),       64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
